// File: rtl/key_conditioner_pkg.sv
// Shared helpers for the input-conditioning blocks.
package key_cond_pkg;

    // Width of a counter that must hold 0 .. d-1, never narrower than one bit.
    function automatic int cnt_width(input int d);
        return (d > 2) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Pin-side and game-side signals of the key conditioner.
// master drives tick/raw pins and observes the conditioned outputs; slave is the conditioner.
interface key_conditioner_if #(
    parameter int N_CH = 4
);
    logic            tick_i;
    logic [N_CH-1:0] in_raw_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;

    modport master (
        output tick_i,
        output in_raw_i,
        input  level_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  tick_i,
        input  in_raw_i,
        output level_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/key_conditioner_ch.sv
// One key channel: synchroniser chain, tick-gated debounce counter, stable level
// and registered press/release pulses. The input is already in logical polarity.
module key_conditioner_ch
    import key_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic in_log_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state: the chain shifts every clock; the counter only advances on
    // qualifying ticks and is cleared whenever the synchronised input agrees
    // with the stable level, so a bounce never carries a partial count forward.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], in_log_i};
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d     = '0;
                level_d   = sync;
                press_d   = sync;
                release_d = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset to "not pressed".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: polarity correction at the pins, then one
// independent synchronise/debounce/edge-pulse channel per key.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               reset,
    key_conditioner_if.slave   bus
);

    if (SYNC_STAGES < 2) begin : g_err_sync
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_err_deb
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_CH-1:0] in_log;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;

    // Invert before the first sync flop so every stage carries 1 = pressed.
    assign in_log = (ACTIVE_LOW != 0) ? ~bus.in_raw_i : bus.in_raw_i;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_conditioner_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (bus.tick_i),
            .in_log_i (in_log[i]),
            .level_o  (level[i]),
            .press_o  (press[i]),
            .release_o(rel[i])
        );
    end

    assign bus.level_o   = level;
    assign bus.press_o   = press;
    assign bus.release_o = rel;

endmodule
